inst_encoder: RTL and testbench
===============================

# inst_encoder

Instruction encoder/program writer for the 18-bit core: accepts one instruction per handshake as class plus field values, packs it into the 18-bit instruction word in exactly the bit layout the instruction splitter decodes, and writes it to program memory at an auto-incrementing address. Sits between the loader/debug front end and the program memory write port, and is the write-side counterpart of the fetch-side field splitter.

## Interface
- ADDR_W, 12: program memory address width.
- DEPTH, 4096: number of writable words; the block saturates at base+DEPTH-1.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  pulse; loads write pointer from base_i, enters RUN.
- base_i  in  ADDR_W  first write address.
- in_valid_i  in  1  instruction fields valid.
- in_ready_o  out  1  block can accept this cycle.
- class_i  in  3  0 ALU, 1 ALU-IMMED, 2 SHIFT, 3 MEM, 4 BRANCH, 5 JUMP, 6 MISC, 7 illegal.
- func_i, rd_i, rs_i, rs2_i, count_i  in  3 each  field values.
- imm_i  in  8  immediate/disp/offset.
- addr_i  in  12  jump target.
- prog_we_o  out  1  program memory write strobe.
- prog_addr_o  out  ADDR_W  write address.
- prog_data_o  out  18  encoded word.
- full_o  out  1  pointer reached base+DEPTH-1 and that word was written.
- err_o  out  1  sticky: an illegal instruction was dropped.
- words_o  out  ADDR_W+1  count of words written since start_i.

## Operation
- States: IDLE, RUN, FULL. Reset -> IDLE. start_i from any state -> RUN, pointer=base_i, words_o=0, err_o=0.
- RUN: in_ready_o=1. Accepted instruction (in_valid_i & in_ready_o) is encoded and, if legal, written; pointer and words_o increment. Writing the DEPTH-th word -> FULL.
- FULL: in_ready_o=0, full_o=1; leaves only on start_i or rst. Pointer never wraps.
- Encodings (bit 17 leftmost, unlisted bits 0):
  - ALU: [17:14]=1110, rd[13:11], rs[10:8], rs2[7:5], func[2:0].
  - ALU-IMMED: [17]=0, func[16:14], rd[13:11], rs[10:8], imm[7:0].
  - SHIFT: [17:15]=110, rd[13:11], rs[10:8], count[7:5], func[2:0].
  - MEM: [17:16]=10, func[15:13], rd[1:0] in [12:11], rs[10:8], imm[7:0]; bit 13 serves both func[0] and rd[2].
  - BRANCH: [17:12]=111110, func[11:9], imm[7:0].
  - JUMP: [17:13]=11110, func[12:10], addr[9:0].
  - MISC: [17:11]=1111110, func[10:8], imm[7:0].
- Illegal: class 7 always; MEM with rd[2]!=func[0]; JUMP with addr[11:10]!=0. Illegal instruction is consumed (handshake completes), not written, pointer unchanged, err_o set.

## Timing
- Reset values: state IDLE, in_ready_o=0, prog_we_o=0, prog_addr_o=0, prog_data_o=0, full_o=0, err_o=0, words_o=0.
- Outputs registered. Handshake in cycle T -> prog_we_o high for exactly cycle T+1 with prog_addr_o/prog_data_o valid; err_o rises in T+1 for illegal input.
- Throughput one word per cycle; no bubbles in RUN.
- Last word: accepted in T, written in T+1, in_ready_o low from T+1, full_o high from T+1.
- start_i same cycle as a handshake: start_i wins, input not accepted (in_ready_o already registered low is not required; the transfer is simply dropped and must not be counted).
- rst mid-stream: pending write in T+1 suppressed.

## Configuration
- INST_ENCODER_CHECK_EN defined: legality checks above active, err_o functional.
- Undefined: no checks, err_o tied 0; class 7 encoded as MISC; MEM bit 13 = func[0]; JUMP drops addr[11:10]. Every accepted input is written.

## Test plan
- start_i base=0x010; ALU func=3 rd=2 rs=1 rs2=5 -> T+1 prog_we_o=1, addr 0x010, data 0x391A3, words_o=1.
- Back-to-back ALU-IMMED func=5 rd=7 rs=0 imm=0xA5, then JUMP func=2 addr=0x3FF, then MISC func=1 imm=0x0F -> data 0x178A5, 0x3CBFF, 0x3F10F at consecutive addresses, consecutive cycles.
- MEM func=4 rd=0 rs=3 imm=0x10 -> 0x28310; then MEM func=4 rd=4 (CHECK_EN) -> no write, err_o=1, pointer unchanged.
- DEPTH=4, base=0: stream 5 valid inputs -> 4 writes at 0..3, full_o=1, in_ready_o=0, fifth not accepted; start_i clears full_o.
- rst asserted the cycle after a handshake -> no prog_we_o pulse, all outputs at reset values.
- Without INST_ENCODER_CHECK_EN: class 7 func=1 imm=0x0F -> written as 0x3F10F, err_o stays 0.

Source files
------------

// File: rtl/inst_encoder_if.sv
// inst_encoder_if: instruction-field handshake channel from the loader into the encoder.
interface inst_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  cls;
  logic [2:0]  func;
  logic [2:0]  rd;
  logic [2:0]  rs;
  logic [2:0]  rs2;
  logic [2:0]  count;
  logic [7:0]  imm;
  logic [11:0] addr;
  modport master (output in_valid, cls, func, rd, rs, rs2, count, imm, addr, input in_ready);
  modport slave (input in_valid, cls, func, rd, rs, rs2, count, imm, addr, output in_ready);
endinterface

// File: rtl/inst_encoder.sv
// inst_encoder: packs instruction fields into 18-bit words and writes them to program memory.
// Legality checking and err_o are enabled by defining INST_ENCODER_CHECK_EN.
module inst_encoder #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_i,
  inst_encoder_if.slave     bus,
  output logic              prog_we_o,
  output logic [ADDR_W-1:0] prog_addr_o,
  output logic [17:0]       prog_data_o,
  output logic              full_o,
  output logic              err_o,
  output logic [ADDR_W:0]   words_o
);
  typedef enum logic [1:0] {IDLE, RUN, FULL} state_t;
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);
  state_t state;
  logic [ADDR_W-1:0] ptr;
  logic we_q, legal, acc;
  logic [17:0] word;
  assign acc = bus.in_valid && state == RUN;
  // a write already registered for the next cycle must not escape while rst is held
  assign prog_we_o = we_q & ~rst;
  always_comb begin
    word = '0;
    case (bus.cls)
      3'd0: word = {4'b1110, bus.rd, bus.rs, bus.rs2, 2'b00, bus.func};
      3'd1: word = {1'b0, bus.func, bus.rd, bus.rs, bus.imm};
      3'd2: word = {4'b1100, bus.rd, bus.rs, bus.count, 2'b00, bus.func};
      3'd3: word = {2'b10, bus.func, bus.rd[1:0], bus.rs, bus.imm};
      3'd4: word = {6'b111110, bus.func, 1'b0, bus.imm};
      3'd5: word = {5'b11110, bus.func, bus.addr[9:0]};
      default: word = {7'b1111110, bus.func, bus.imm};
    endcase
`ifdef INST_ENCODER_CHECK_EN
    legal = !(bus.cls == 3'd7 || (bus.cls == 3'd3 && bus.rd[2] != bus.func[0]) ||
              (bus.cls == 3'd5 && bus.addr[11:10] != 2'b00));
`else
    legal = 1'b1;
`endif
  end
`ifndef INST_ENCODER_CHECK_EN
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.addr[11:10];
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= '0;
      we_q         <= 1'b0;
      prog_addr_o  <= '0;
      prog_data_o  <= '0;
      full_o       <= 1'b0;
      err_o        <= 1'b0;
      words_o      <= '0;
      bus.in_ready <= 1'b0;
    end else begin
      we_q <= 1'b0;
      if (start_i) begin
        state        <= RUN;
        ptr          <= base_i;
        words_o      <= '0;
        err_o        <= 1'b0;
        full_o       <= 1'b0;
        bus.in_ready <= 1'b1;
      end else if (acc && legal) begin
        we_q        <= 1'b1;
        prog_addr_o <= ptr;
        prog_data_o <= word;
        ptr         <= ptr + 1'b1;
        words_o     <= words_o + 1'b1;
        if (words_o == LAST) begin
          state        <= FULL;
          full_o       <= 1'b1;
          bus.in_ready <= 1'b0;
        end
      end else if (acc) begin
        err_o <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: scoreboard bench; expected writes are queued at drive time and matched on prog_we_o.
module tb_inst_encoder;
  typedef struct {
    int          cyc;
    logic [11:0] a;
    logic [17:0] d;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic [11:0] base_i = '0;
  logic        prog_we_o;
  logic [11:0] prog_addr_o;
  logic [17:0] prog_data_o;
  logic        full_o, err_o;
  logic [12:0] words_o;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [11:0] exp_ptr = '0;
  exp_t        sb[$];
  inst_encoder_if bus();
  inst_encoder #(.ADDR_W(12), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .base_i(base_i), .bus(bus),
    .prog_we_o(prog_we_o), .prog_addr_o(prog_addr_o), .prog_data_o(prog_data_o),
    .full_o(full_o), .err_o(err_o), .words_o(words_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (prog_we_o === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got addr=%h data=%h cyc=%0d want none", prog_addr_o, prog_data_o, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (prog_addr_o !== e.a || prog_data_o !== e.d || cyc != e.cyc) begin
          errors++;
          $display("FAIL write got addr=%h data=%h cyc=%0d want addr=%h data=%h cyc=%0d",
                   prog_addr_o, prog_data_o, cyc, e.a, e.d, e.cyc);
        end
      end
    end
  end
  task automatic xfer(input logic [2:0] c, f, d, s, s2, n, input logic [7:0] im, input logic [11:0] a,
                      input bit rdy, input bit wr, input logic [17:0] dat, input string nm);
    bus.cls = c; bus.func = f; bus.rd = d; bus.rs = s; bus.rs2 = s2; bus.count = n;
    bus.imm = im; bus.addr = a; bus.in_valid = 1'b1;
    checks++;
    if (bus.in_ready !== rdy) begin
      errors++;
      $display("FAIL %s in_ready got %b want %b", nm, bus.in_ready, rdy);
    end
    if (wr) begin
      sb.push_back('{cyc + 1, exp_ptr, dat});
      exp_ptr++;
    end
    @(posedge clk); #1;
  endtask
  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic check_words(input logic [12:0] w, input string nm);
    checks++;
    if (words_o !== w) begin
      errors++;
      $display("FAIL %s words_o got %0d want %0d", nm, words_o, w);
    end
  endtask
  task automatic do_start(input logic [11:0] b);
    start_i = 1'b1; base_i = b; bus.in_valid = 1'b0;
    @(posedge clk); #1;
    start_i = 1'b0; exp_ptr = b;
    checks++;
    if ({bus.in_ready, full_o, err_o, words_o} !== {1'b1, 1'b0, 1'b0, 13'd0}) begin
      errors++;
      $display("FAIL start rdy/full/err/words got %b %b %b %0d want 1 0 0 0", bus.in_ready, full_o, err_o, words_o);
    end
  endtask
  task automatic check_reset_vals(input string nm);
    checks++;
    if ({bus.in_ready, prog_we_o, prog_addr_o, prog_data_o, full_o, err_o, words_o} !== '0) begin
      errors++;
      $display("FAIL %s got rdy=%b we=%b addr=%h data=%h full=%b err=%b words=%0d want all 0",
               nm, bus.in_ready, prog_we_o, prog_addr_o, prog_data_o, full_o, err_o, words_o);
    end
  endtask
  task automatic test_reset;
    rst = 1'b1; bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    check_reset_vals("idle_after_reset");
  endtask
  task automatic test_alu;
    do_start(12'h010);
    xfer(3'd0, 3'd3, 3'd2, 3'd1, 3'd5, 3'd0, 8'h00, 12'h000, 1, 1, 18'h391A3, "alu");
    idle(2);
    check_words(13'd1, "alu");
  endtask
  task automatic test_back_to_back;
    do_start(12'h020);
    xfer(3'd1, 3'd5, 3'd7, 3'd0, 3'd0, 3'd0, 8'hA5, 12'h000, 1, 1, 18'h178A5, "b2b_alui");
    xfer(3'd5, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 8'h00, 12'h3FF, 1, 1, 18'h3CBFF, "b2b_jump");
    xfer(3'd6, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 8'h0F, 12'h000, 1, 1, 18'h3F10F, "b2b_misc");
    idle(2);
    check_words(13'd3, "b2b");
  endtask
  task automatic test_mem;
    bit chk;
`ifdef INST_ENCODER_CHECK_EN
    chk = 1;
`else
    chk = 0;
`endif
    do_start(12'h030);
    xfer(3'd3, 3'd4, 3'd0, 3'd3, 3'd0, 3'd0, 8'h10, 12'h000, 1, 1, 18'h28310, "mem_ok");
    xfer(3'd3, 3'd4, 3'd4, 3'd3, 3'd0, 3'd0, 8'h10, 12'h000, 1, !chk, 18'h28310, "mem_bad");
    checks++;
    if (err_o !== chk) begin
      errors++;
      $display("FAIL mem_bad err_o got %b want %b", err_o, chk);
    end
    xfer(3'd3, 3'd5, 3'd4, 3'd1, 3'd0, 3'd0, 8'hFF, 12'h000, 1, 1, 18'h2A1FF, "mem_ok2");
    xfer(3'd5, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 8'h00, 12'h400, 1, !chk, 18'h3C000, "jump_hi");
    idle(2);
    check_words(chk ? 13'd2 : 13'd4, "mem");
    checks++;
    if (err_o !== chk) begin
      errors++;
      $display("FAIL mem err_sticky got %b want %b", err_o, chk);
    end
  endtask
  task automatic test_class7;
    bit chk;
`ifdef INST_ENCODER_CHECK_EN
    chk = 1;
`else
    chk = 0;
`endif
    do_start(12'h0A0);
    xfer(3'd7, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 8'h0F, 12'h000, 1, !chk, 18'h3F10F, "class7");
    idle(2);
    checks++;
    if (err_o !== chk) begin
      errors++;
      $display("FAIL class7 err_o got %b want %b", err_o, chk);
    end
  endtask
  task automatic test_full;
    do_start(12'h000);
    for (int i = 0; i < 5; i++)
      xfer(3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 8'(i), 12'h000, i < 4, i < 4, 18'(i), "full_stream");
    idle(3);
    checks++;
    if ({full_o, bus.in_ready, words_o} !== {1'b1, 1'b0, 13'd4}) begin
      errors++;
      $display("FAIL full got full=%b rdy=%b words=%0d want 1 0 4", full_o, bus.in_ready, words_o);
    end
    do_start(12'h000);
  endtask
  task automatic test_start_collision;
    do_start(12'h040);
    bus.cls = 3'd0; bus.func = 3'd1; bus.rd = 3'd1; bus.rs = 3'd1; bus.rs2 = 3'd1;
    bus.in_valid = 1'b1; start_i = 1'b1; base_i = 12'h050;
    @(posedge clk); #1;
    start_i = 1'b0; exp_ptr = 12'h050;
    check_words(13'd0, "collision");
    xfer(3'd2, 3'd6, 3'd3, 3'd4, 3'd0, 3'd7, 8'h00, 12'h000, 1, 1, 18'h31CE6, "shift_after");
    idle(2);
    check_words(13'd1, "collision_after");
  endtask
  task automatic test_rst_mid;
    do_start(12'h060);
    xfer(3'd4, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 8'h80, 12'h000, 1, 0, 18'h0, "rst_mid");
    rst = 1'b1; bus.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (prog_we_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid prog_we_o got %b want 0", prog_we_o);
    end
    @(posedge clk); #1;
    check_reset_vals("rst_mid");
    rst = 1'b0;
  endtask
  initial begin
    bus.in_valid = 1'b0; bus.cls = '0; bus.func = '0; bus.rd = '0; bus.rs = '0;
    bus.rs2 = '0; bus.count = '0; bus.imm = '0; bus.addr = '0;
    test_reset();
    test_alu();
    test_back_to_back();
    test_mem();
    test_class7();
    test_full();
    test_start_collision();
    test_rst_mid();
    idle(3);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending writes got %0d want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
